// File: rtl/operand_packer.sv
// rtl/operand_packer.sv - packs a stream of operand words into fixed-size groups
// Words fill slots LSB-first; a group is presented when full or closed early by in_last.
module operand_packer #(
  parameter int WIDTH   = 16,
  parameter int NUM_OPS = 2,
  localparam int CW     = $clog2(NUM_OPS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_OPS*WIDTH-1:0] out_ops,
  output logic [CW-1:0]            out_count,
  output logic                     out_partial
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                     state, state_n;
  logic [CW-1:0]              fill_cnt, fill_n;
  logic [NUM_OPS*WIDTH-1:0]   slots, slots_n;
  logic [CW-1:0]              count_q, count_n;
  logic                       partial_q, partial_n;
  logic                       in_beat, out_beat, last_slot;

  assign in_ready  = !rst && ((state == COLLECT) || out_ready);
  assign out_valid = (state == HOLD);
  assign in_beat   = in_valid && in_ready;
  assign out_beat  = out_valid && out_ready;
  assign last_slot = (fill_cnt == CW'(NUM_OPS - 1));

  assign out_ops     = slots;
  assign out_count   = count_q;
  assign out_partial = partial_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      fill_cnt  <= '0;
      slots     <= '0;
      count_q   <= '0;
      partial_q <= 1'b0;
    end else begin
      state     <= state_n;
      fill_cnt  <= fill_n;
      slots     <= slots_n;
      count_q   <= count_n;
      partial_q <= partial_n;
    end
  end

  always_comb begin
    state_n   = state;
    fill_n    = fill_cnt;
    slots_n   = slots;
    count_n   = count_q;
    partial_n = partial_q;
    case (state)
      COLLECT: begin
        if (clr) begin
          // clr wins over a same-cycle input beat
          slots_n = '0;
          fill_n  = '0;
        end else if (in_beat) begin
          for (int k = 0; k < NUM_OPS; k++) begin
            if (fill_cnt == CW'(k)) slots_n[k*WIDTH +: WIDTH] = in_data;
          end
          fill_n = fill_cnt + CW'(1);
          if (last_slot || in_last) begin
            state_n   = HOLD;
            count_n   = fill_cnt + CW'(1);
            partial_n = !last_slot;
          end
        end
      end
      HOLD: begin
        if (out_beat) begin
          slots_n   = '0;
          fill_n    = '0;
          state_n   = COLLECT;
          count_n   = '0;
          partial_n = 1'b0;
          // in HOLD an input beat implies an output beat; the word opens the next group
          if (in_beat) begin
            slots_n[WIDTH-1:0] = in_data;
            fill_n             = CW'(1);
            if (in_last) begin
              state_n   = HOLD;
              count_n   = CW'(1);
              partial_n = 1'b1;
            end
          end
        end
      end
      default: state_n = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_operand_packer.sv
// tb/tb_operand_packer.sv - directed self-checking bench for operand_packer
// Two instances (2 and 4 operands per group) share one input stream.
module tb_operand_packer;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_last, out_ready;
  logic [15:0] in_data;

  logic        in_ready2, out_valid2, out_partial2;
  logic [31:0] out_ops2;
  logic [1:0]  out_count2;

  logic        in_ready4, out_valid4, out_partial4;
  logic [63:0] out_ops4;
  logic [2:0]  out_count4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  operand_packer #(.WIDTH(16), .NUM_OPS(2)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
    .out_ops(out_ops2), .out_count(out_count2), .out_partial(out_partial2)
  );

  operand_packer #(.WIDTH(16), .NUM_OPS(4)) u_dut4 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready),
    .out_ops(out_ops4), .out_count(out_count4), .out_partial(out_partial4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = 16'h0; out_ready = 1'b1;

    // reset state
    tick(); tick();
    chk("rst_in_ready2", in_ready2, 0);
    chk("rst_in_ready4", in_ready4, 0);
    chk("rst_valid2", out_valid2, 0);
    chk("rst_ops2", out_ops2, 0);
    chk("rst_count2", out_count2, 0);
    chk("rst_partial2", out_partial2, 0);
    chk("rst_ops4", out_ops4, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready2", in_ready2, 1);

    // basic two-word group
    push(16'h1111, 1'b0);
    chk("s1_valid_mid", out_valid2, 0);
    push(16'h2222, 1'b0);
    chk("s1_valid", out_valid2, 1);
    chk("s1_ops", out_ops2, 32'h2222_1111);
    chk("s1_count", out_count2, 2);
    chk("s1_partial", out_partial2, 0);
    idle();
    tick();
    chk("s1_valid_drop", out_valid2, 0);
    chk("s1_ops_clear", out_ops2, 0);

    // early close on 4-op instance; full close on 2-op instance
    do_reset();
    push(16'hAAAA, 1'b0);
    push(16'hBBBB, 1'b1);
    chk("s2_valid4", out_valid4, 1);
    chk("s2_ops4", out_ops4, 64'h0000_0000_BBBB_AAAA);
    chk("s2_count4", out_count4, 2);
    chk("s2_partial4", out_partial4, 1);
    chk("s2_ops2", out_ops2, 32'hBBBB_AAAA);
    chk("s2_partial2", out_partial2, 0);
    idle();
    tick();
    push(16'h1111, 1'b0);
    push(16'h2222, 1'b0);
    push(16'h3333, 1'b0);
    chk("s2_full_notyet", out_valid4, 0);
    push(16'h4444, 1'b1);
    chk("s2_full_ops4", out_ops4, 64'h4444_3333_2222_1111);
    chk("s2_full_count4", out_count4, 4);
    chk("s2_full_partial4", out_partial4, 0);
    push(16'h7A7A, 1'b1);
    chk("s2_reload_valid4", out_valid4, 1);
    chk("s2_reload_ops4", out_ops4, 64'h7A7A);
    chk("s2_reload_count4", out_count4, 1);
    chk("s2_reload_partial4", out_partial4, 1);
    idle();
    tick();
    chk("s2_drain4", out_valid4, 0);

    // back-pressure and simultaneous consume/accept
    do_reset();
    out_ready = 1'b0;
    push(16'h7777, 1'b0);
    push(16'h8888, 1'b0);
    in_data = 16'h9999;
    for (int i = 0; i < 5; i++) begin
      chk("s3_stall_in_ready", in_ready2, 0);
      chk("s3_stall_ops", out_ops2, 32'h8888_7777);
      chk("s3_stall_valid", out_valid2, 1);
      tick();
    end
    out_ready = 1'b1;
    in_data   = 16'h3333;
    #1;
    chk("s3_release_in_ready", in_ready2, 1);
    tick();
    chk("s3_consumed_valid", out_valid2, 0);
    chk("s3_slot0", out_ops2, 32'h0000_3333);
    push(16'h4444, 1'b0);
    chk("s3_next_ops", out_ops2, 32'h4444_3333);
    chk("s3_next_valid", out_valid2, 1);
    idle();
    tick();

    // continuous streaming
    do_reset();
    for (int i = 0; i < 12; i++) begin
      push(16'h0100 + 16'(i), 1'b0);
      chk("s4_valid", out_valid2, (i % 2) == 1);
      if (i % 2 == 1) chk("s4_ops", out_ops2, {16'h0100 + 16'(i), 16'h0100 + 16'(i - 1)});
    end
    idle();
    tick();
    chk("s4_drain", out_valid2, 0);

    // clr in COLLECT, clr in HOLD, clr when empty
    do_reset();
    clr = 1'b1;
    tick();
    chk("s5_clr_empty_ops", out_ops2, 0);
    chk("s5_clr_empty_valid", out_valid2, 0);
    clr = 1'b0;
    push(16'h1234, 1'b0);
    clr = 1'b1;
    push(16'hDEAD, 1'b0);
    chk("s5_clr_ops", out_ops2, 0);
    chk("s5_clr_valid", out_valid2, 0);
    clr = 1'b0;
    push(16'h5555, 1'b0);
    push(16'h6666, 1'b0);
    chk("s5_group", out_ops2, 32'h6666_5555);
    idle();
    out_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("s5_hold_clr_valid", out_valid2, 1);
    chk("s5_hold_clr_ops", out_ops2, 32'h6666_5555);
    chk("s5_hold_clr_count", out_count2, 2);
    out_ready = 1'b1;
    tick();

    // reset mid-group and in HOLD
    do_reset();
    push(16'hABCD, 1'b0);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_mid_ops", out_ops2, 0);
    chk("s6_mid_valid", out_valid2, 0);
    push(16'h1357, 1'b0);
    push(16'h2468, 1'b0);
    chk("s6_after_mid", out_ops2, 32'h2468_1357);
    idle();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("s6_hold_valid", out_valid2, 0);
    chk("s6_hold_ops", out_ops2, 0);
    chk("s6_hold_count", out_count2, 0);
    chk("s6_hold_partial", out_partial2, 0);
    push(16'h0F0F, 1'b0);
    push(16'hF0F0, 1'b0);
    chk("s6_after_hold", out_ops2, 32'hF0F0_0F0F);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_packer.md
OPERAND_PACKER -- requirements
Module: operand_packer

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the bit width of one operand word.
REQ-002 The block SHALL have parameter NUM_OPS, default 2, meaning operands per group; legal range 2..8.
REQ-003 The block SHALL have localparam CW = $clog2(NUM_OPS+1), meaning the width of the fill counter.

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous discard of the partial group.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream word valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-009 The block SHALL have port in_data, input, WIDTH bits: operand word.
REQ-010 The block SHALL have port in_last, input, 1 bit: the current word closes the group early.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a packed group is presented.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the group.
REQ-013 The block SHALL have port out_ops, output, NUM_OPS*WIDTH bits: slot k at bits [k*WIDTH +: WIDTH].
REQ-014 The block SHALL have port out_count, output, CW bits: number of valid slots in the presented group (1..NUM_OPS).
REQ-015 The block SHALL have port out_partial, output, 1 bit: the group closed before NUM_OPS words.

Function
REQ-016 The block SHALL implement a two-state FSM: COLLECT (filling, out_valid=0) and HOLD (group presented, out_valid=1).
REQ-017 in_ready SHALL equal (state==COLLECT) OR out_ready, combinationally; in_ready SHALL be 0 while rst=1.
REQ-018 An input beat SHALL occur when in_valid & in_ready; an output beat SHALL occur when out_valid & out_ready.
REQ-019 On an input beat in COLLECT, in_data SHALL be written to slot fill_cnt and fill_cnt SHALL increment by 1.
REQ-020 Slots SHALL fill in arrival order: first word to slot 0 (LSBs), last to slot NUM_OPS-1.
REQ-021 When the input beat fills slot NUM_OPS-1, the FSM SHALL enter HOLD next cycle with out_count=NUM_OPS and out_partial=0.
REQ-022 When an input beat has in_last=1 and fill_cnt+1<NUM_OPS, the FSM SHALL enter HOLD next cycle with out_count=fill_cnt+1, out_partial=1, and all unwritten slots reading 0.
REQ-023 in_last on the beat that fills slot NUM_OPS-1 SHALL produce a full group (out_partial=0).
REQ-024 In HOLD, out_ops, out_count and out_partial SHALL remain stable until the output beat.
REQ-025 On an output beat with no simultaneous input beat, the FSM SHALL return to COLLECT with fill_cnt=0 and all slots cleared to 0.
REQ-026 On an output beat with a simultaneous input beat, the incoming word SHALL go to slot 0 of the new group, other slots SHALL clear, and fill_cnt SHALL become 1; if that word has in_last=1, or NUM_OPS==1 would apply, the FSM SHALL stay in HOLD with the new one-word group.
REQ-027 Sustained throughput SHALL be one word per cycle with out_ready held 1; latency from the last word's input beat to out_valid=1 SHALL be exactly 1 cycle.
REQ-028 clr=1 in COLLECT SHALL zero all slots and fill_cnt and SHALL ignore any same-cycle input beat; clr=1 in HOLD SHALL have no effect.
REQ-029 A clr with nothing collected SHALL be a no-op.
REQ-030 in_data SHALL NOT be captured when in_valid=0, regardless of in_last.

Reset
REQ-031 While rst=1 at a clock edge, the block SHALL set the state to COLLECT, fill_cnt=0, all slots to 0, out_valid=0, out_count=0, out_partial=0; rst SHALL take priority over clr and any beat.
REQ-032 A reset asserted mid-group or in HOLD SHALL discard that group with no output beat; the first word after rst deasserts SHALL go to slot 0.

Verification
REQ-033 Bench scenario: NUM_OPS=2, WIDTH=16, words 0x1111 then 0x2222, out_ready=1 -> out_valid for 1 cycle, out_ops=0x2222_1111, out_count=2, out_partial=0.
REQ-034 Bench scenario: NUM_OPS=4, words 0xAAAA, 0xBBBB with in_last on the second -> out_ops=0x0000_0000_BBBB_AAAA, out_count=2, out_partial=1.
REQ-035 Bench scenario: NUM_OPS=2, out_ready=0 after a group completes -> in_ready=0 and out_ops stable for 5 cycles; out_ready=1 together with in_valid 0x3333 -> group consumed and 0x3333 in slot 0, fill_cnt=1.
REQ-036 Bench scenario: continuous in_valid=1 with incrementing data and out_ready=1 -> one group every NUM_OPS cycles, no word lost or duplicated.
REQ-037 Bench scenario: clr after one word in COLLECT, then 0x5555, 0x6666 -> group=0x6666_5555; clr in HOLD -> group unchanged.
REQ-038 Bench scenario: rst asserted after the first word and in HOLD -> all outputs 0 the next cycle, and the next group starts at slot 0.
